icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Sequencing controller for the direct-mapped instruction cache.
- Accepts fetch requests from the frontend and runs lookups against the synchronous tag and data arrays.
- On a miss, refills the full line from the memory side one word per beat, then returns the requested word.
- Invalidates all lines after reset and on a flush command by sweeping the tag array.

Parameters:
- WDSZ, 32, address and data word width.
- LADDRSZ, 10, line index bits; LNUM = 2**LADDRSZ lines.
- WADDRSZ, 4, word-in-line bits; WNUM = 2**WADDRSZ words per line.
- Derived: byte offset is 2 bits; TAGSZ = WDSZ-LADDRSZ-WADDRSZ-2 = 16.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  controller can accept a request.
- req_addr  in  WDSZ  byte address; low 2 bits ignored.
- resp_valid  out  1  one-cycle pulse; fetched word valid.
- resp_data  out  WDSZ  fetched word.
- flush  in  1  invalidate-all request, pulse.
- flush_done  out  1  one-cycle pulse when a sweep completes.
- tag_en  out  1  tag array access enable.
- tag_we  out  1  tag array write enable.
- tag_idx  out  LADDRSZ  tag array index.
- tag_wdata  out  TAGSZ  tag to write.
- tag_wvalid  out  1  valid bit to write.
- tag_rdata  in  TAGSZ  tag read, returned 1 cycle after tag_en.
- tag_rvalid  in  1  valid bit read, returned 1 cycle after tag_en.
- data_en  out  1  data array access enable.
- data_we  out  1  data array write enable.
- data_idx  out  LADDRSZ+WADDRSZ  index formed as {line, word}.
- data_wdata  out  WDSZ  data array write word.
- data_rdata  in  WDSZ  data array read word, 1-cycle latency.
- mem_req_valid  out  1  line refill request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  WDSZ  line-aligned byte address; low WADDRSZ+2 bits zero.
- mem_resp_valid  in  1  refill beat valid.
- mem_resp_data  in  WDSZ  refill word; beats arrive in order, word 0 first.

Behaviour:
- Reset (async assert): state=FLUSH, sweep counter=0, all outputs 0.
- Any operation in progress when reset asserts is abandoned; partially refilled lines stay invalid.
- States: FLUSH, IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- FLUSH:
  - Each cycle drives tag_en=tag_we=1, tag_idx=cnt, tag_wvalid=0; cnt increments.
  - On cnt=LNUM-1: flush_done=1 for 1 cycle, go to IDLE.
  - Sweep takes exactly LNUM cycles; req_ready=0 throughout.
- IDLE:
  - req_ready=1 unless a flush is pending.
  - A flush (input or pending flag) has priority over req_valid: go to FLUSH with cnt=0.
  - A flush asserted in any non-IDLE state sets a pending flag. The current operation completes, then FLUSH starts. Multiple pulses collapse into one sweep.
  - On req_valid&&req_ready: latch the address; drive tag_en=1 and data_en=1 with idx {laddr, waddr}; go to LOOKUP.
- LOOKUP:
  - hit = tag_rvalid && tag_rdata==latched tag.
  - Hit: resp_valid=1, resp_data=data_rdata, go to IDLE. Hit latency is 2 cycles from acceptance; peak throughput is 1 request per 2 cycles.
  - Miss: go to MISS_REQ.
- MISS_REQ: mem_req_valid=1 with mem_req_addr line-aligned, held stable until mem_req_ready; then go to REFILL with beat=0.
- REFILL:
  - Each mem_resp_valid beat writes the data array: data_en=data_we=1, idx {laddr, beat}, then beat++.
  - The beat where beat==latched waddr captures the word into the response register.
  - The final beat (beat=WNUM-1) also writes the tag in the same cycle: tag_we=1, tag_wdata=latched tag, tag_wvalid=1. Then go to RESP.
  - Cycles without mem_resp_valid: no array writes.
- RESP: resp_valid=1 with the captured word; go to IDLE.
- resp_valid is never asserted for more than 1 cycle; there is no response backpressure.
- mem_resp_valid outside REFILL is ignored.
- resp_data is 0 whenever resp_valid=0.
- Array enables are 0 in every state/cycle not listed above.

Test Plan:
- Reset release -> req_ready=0 for exactly 1024 cycles; tag writes idx 0..1023 with wvalid=0; flush_done pulses on the cycle idx=1023, then req_ready=1.
- Cold fetch 0x0000_1048 -> mem_req_addr=0x0000_1040; 16 beats D0..D15 written to idx {0x041, 0..15}; tag 0x0000 written valid; resp_data=D2 in RESP.
- Repeat fetch 0x0000_104C -> no mem_req_valid; resp_valid exactly 2 cycles after acceptance with D3.
- Fetch 0x0001_1048 (same index, tag 0x0001) -> miss, refill from 0x0001_1040, then a new fetch to 0x0000_1048 misses again.
- flush pulse during REFILL beat 5 -> refill completes and resp issued, then FLUSH sweep; subsequent fetch of 0x0000_1048 misses.
- reset_n low during REFILL beat 7 -> outputs 0 immediately; re-sweep follows; no resp_valid for the abandoned request.
- mem_req_ready held low 10 cycles -> mem_req_valid and address stable throughout; beats with gaps are counted correctly.

Source files
------------

// File: rtl/icache_ctrl.sv
// icache_ctrl: lookup/refill/flush sequencer for a direct-mapped instruction cache
module icache_ctrl #(
  parameter  int WDSZ    = 32,
  parameter  int LADDRSZ = 10,
  parameter  int WADDRSZ = 4,
  localparam int TAGSZ   = WDSZ - LADDRSZ - WADDRSZ - 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WDSZ-1:0]            req_addr,
  output logic                       resp_valid,
  output logic [WDSZ-1:0]            resp_data,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       tag_en,
  output logic                       tag_we,
  output logic [LADDRSZ-1:0]         tag_idx,
  output logic [TAGSZ-1:0]           tag_wdata,
  output logic                       tag_wvalid,
  input  logic [TAGSZ-1:0]           tag_rdata,
  input  logic                       tag_rvalid,
  output logic                       data_en,
  output logic                       data_we,
  output logic [LADDRSZ+WADDRSZ-1:0] data_idx,
  output logic [WDSZ-1:0]            data_wdata,
  input  logic [WDSZ-1:0]            data_rdata,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [WDSZ-1:0]            mem_req_addr,
  input  logic                       mem_resp_valid,
  input  logic [WDSZ-1:0]            mem_resp_data
);
  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESP} state_t;
  state_t state, state_n;
  logic [LADDRSZ-1:0] cnt, line_q;
  logic [WADDRSZ-1:0] beat, word_q;
  logic [TAGSZ-1:0]   tag_q;
  logic [WDSZ-1:0]    rbuf;
  logic               pend;
  logic               unused_ok;
  // the byte offset inside a word never matters for instruction fetch
  assign unused_ok = ^req_addr[1:0];
  // state register; reset restarts with an invalidate sweep
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_FLUSH;
    else state <= state_n;
  // sweep/beat counters, pending flush, latched request and captured word
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt    <= '0;
      beat   <= '0;
      pend   <= 1'b0;
      tag_q  <= '0;
      line_q <= '0;
      word_q <= '0;
      rbuf   <= '0;
    end else begin
      cnt  <= (state == S_FLUSH) ? cnt + LADDRSZ'(1) : '0;
      beat <= (state == S_REFILL) ? beat + WADDRSZ'(mem_resp_valid) : '0;
      pend <= (state != S_IDLE) && (state != S_FLUSH) && (pend || flush);
      if (req_valid && req_ready) {tag_q, line_q, word_q} <= req_addr[WDSZ-1:2];
      if (state == S_REFILL && mem_resp_valid && beat == word_q) rbuf <= mem_resp_data;
    end
  // next state and array/memory/frontend strobes; everything held at 0 during reset
  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    flush_done    = 1'b0;
    tag_en        = 1'b0;
    tag_we        = 1'b0;
    tag_idx       = '0;
    tag_wdata     = '0;
    tag_wvalid    = 1'b0;
    data_en       = 1'b0;
    data_we       = 1'b0;
    data_idx      = '0;
    data_wdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    if (reset_n)
      case (state)
        S_FLUSH: begin
          tag_en  = 1'b1;
          tag_we  = 1'b1;
          tag_idx = cnt;
          if (&cnt) begin
            flush_done = 1'b1;
            state_n    = S_IDLE;
          end
        end
        S_IDLE: begin
          req_ready = !pend && !flush;
          if (pend || flush) state_n = S_FLUSH;
          else if (req_valid) begin
            tag_en   = 1'b1;
            data_en  = 1'b1;
            tag_idx  = req_addr[LADDRSZ+WADDRSZ+1:WADDRSZ+2];
            data_idx = req_addr[LADDRSZ+WADDRSZ+1:2];
            state_n  = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          resp_valid = tag_rvalid && tag_rdata == tag_q;
          resp_data  = resp_valid ? data_rdata : '0;
          state_n    = resp_valid ? S_IDLE : S_MISS_REQ;
        end
        S_MISS_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {tag_q, line_q, (WADDRSZ+2)'(0)};
          state_n       = mem_req_ready ? S_REFILL : S_MISS_REQ;
        end
        S_REFILL:
          if (mem_resp_valid) begin
            data_en    = 1'b1;
            data_we    = 1'b1;
            data_idx   = {line_q, beat};
            data_wdata = mem_resp_data;
            if (&beat) begin
              tag_en     = 1'b1;
              tag_we     = 1'b1;
              tag_idx    = line_q;
              tag_wdata  = tag_q;
              tag_wvalid = 1'b1;
              state_n    = S_RESP;
            end
          end
        S_RESP: begin
          resp_valid = 1'b1;
          resp_data  = rbuf;
          state_n    = S_IDLE;
        end
        default: state_n = S_FLUSH;
      endcase
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: table, corner-case and random checks of icache_ctrl against a cache-content model
module tb_icache_ctrl;
  logic        clock = 1'b0, reset_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, resp_valid, flush = 1'b0, flush_done;
  logic [31:0] req_addr = '0, resp_data;
  logic        tag_en, tag_we, tag_wvalid, tag_rvalid, data_en, data_we;
  logic [9:0]  tag_idx;
  logic [15:0] tag_wdata, tag_rdata;
  logic [13:0] data_idx;
  logic [31:0] data_wdata, data_rdata, mem_req_addr, mem_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  int          nvec = 0, nerr = 0, rdy_delay = 0;
  logic        gap_en = 1'b0;
  logic [15:0] ttag [1024];
  logic        tval [1024];
  logic [31:0] dram [16384];
  logic        valid_m [1024];
  logic [15:0] tag_m [1024];
  typedef struct {logic [31:0] addr; logic miss;} vec_t;
  vec_t tbl [8];

  icache_ctrl dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
    .flush_done(flush_done), .tag_en(tag_en), .tag_we(tag_we), .tag_idx(tag_idx),
    .tag_wdata(tag_wdata), .tag_wvalid(tag_wvalid), .tag_rdata(tag_rdata),
    .tag_rvalid(tag_rvalid), .data_en(data_en), .data_we(data_we), .data_idx(data_idx),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clock = ~clock;

  // synchronous tag and data arrays, one-cycle read latency
  always @(posedge clock) begin
    if (tag_en) begin
      if (tag_we) begin
        ttag[tag_idx] <= tag_wdata;
        tval[tag_idx] <= tag_wvalid;
      end else begin
        tag_rdata  <= ttag[tag_idx];
        tag_rvalid <= tval[tag_idx];
      end
    end
    if (data_en) begin
      if (data_we) dram[data_idx] <= data_wdata;
      else data_rdata <= dram[data_idx];
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h3C6E_F372;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // backing memory: optional accept delay with stability checks, then 16 in-order beats
  initial begin : memsim
    logic [31:0] la;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(negedge clock);
      if (mem_req_valid) begin
        la = mem_req_addr;
        for (int i = 0; i < rdy_delay; i++) begin
          chk("mem_req held", {31'b0, mem_req_valid}, 32'd1);
          chk("mem_req_addr stable", mem_req_addr, la);
          @(negedge clock);
        end
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 16; b++) begin
          while (gap_en && $urandom_range(0, 2) == 0) begin
            mem_resp_valid = 1'b0;
            @(negedge clock);
          end
          mem_resp_valid = 1'b1;
          mem_resp_data = mem_word(la + 32'(4 * b));
          @(negedge clock);
        end
        mem_resp_valid = 1'b0;
      end
    end
  end

  task automatic clr_model();
    for (int i = 0; i < 1024; i++) valid_m[i] = 1'b0;
  endtask

  // release reset and verify the full invalidate sweep
  task automatic sweep_check(input string nm);
    int bad, fd_at, fdn;
    bad = 0; fd_at = -1; fdn = 0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clock);
      if (req_ready || !tag_en || !tag_we || tag_wvalid || tag_idx != 10'(i) || data_en || resp_valid) bad++;
      if (flush_done) begin fd_at = i; fdn++; end
    end
    chk({nm, " sweep cycles"}, 32'(bad), 0);
    chk({nm, " flush_done idx"}, 32'(fd_at), 1023);
    chk({nm, " flush_done count"}, 32'(fdn), 1);
    @(negedge clock);
    chk({nm, " ready after sweep"}, {31'b0, req_ready}, 1);
    clr_model();
  endtask

  task automatic wait_flush_done(input string nm);
    int n;
    n = 0;
    while (!flush_done && n < 1200) begin @(negedge clock); n++; end
    chk({nm, " flush_done seen"}, {31'b0, flush_done}, 1);
    @(negedge clock);
    clr_model();
  endtask

  // one fetch: checks miss/hit, refill address, word, hit latency and pulse shape
  task automatic run(input logic [31:0] a, input logic exp_miss, input string nm);
    logic miss;
    logic [31:0] maddr, data;
    int lat, bad, n;
    n = 0;
    while (!req_ready && n < 3000) begin @(negedge clock); n++; end
    chk({nm, " ready"}, {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_addr = a;
    miss = 1'b0; maddr = '0; bad = 0; lat = 1;
    @(negedge clock);
    req_valid = 1'b0; req_addr = $urandom;
    lat = 2;
    while (!resp_valid && lat < 400) begin
      if (resp_data != 0) bad++;
      if (mem_req_valid && !miss) begin miss = 1'b1; maddr = mem_req_addr; end
      @(negedge clock);
      lat++;
    end
    data = resp_data;
    chk({nm, " resp_valid"}, {31'b0, resp_valid}, 1);
    chk({nm, " miss"}, {31'b0, miss}, {31'b0, exp_miss});
    chk({nm, " mem_req_addr"}, maddr, exp_miss ? {a[31:6], 6'b0} : 32'h0);
    chk({nm, " resp_data"}, data, mem_word(a));
    chk({nm, " idle resp_data zero"}, 32'(bad), 0);
    if (!exp_miss) chk({nm, " hit latency"}, 32'(lat), 2);
    @(negedge clock);
    chk({nm, " resp pulse"}, {31'b0, resp_valid}, 0);
    valid_m[a[15:6]] = 1'b1;
    tag_m[a[15:6]] = a[31:16];
  endtask

  task automatic chk_line(input logic [31:0] a, input string nm);
    int bad;
    bad = 0;
    for (int b = 0; b < 16; b++)
      if (dram[{a[15:6], 4'(b)}] !== mem_word({a[31:6], 4'(b), 2'b00})) bad++;
    chk({nm, " line words"}, 32'(bad), 0);
    chk({nm, " line tag"}, {15'b0, tval[a[15:6]], ttag[a[15:6]]}, {15'b0, 1'b1, a[31:16]});
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] a;
    tbl = '{'{32'h0000_1048, 1'b1}, '{32'h0000_104C, 1'b0}, '{32'h0001_1048, 1'b1},
            '{32'h0000_1048, 1'b1}, '{32'h0000_1044, 1'b0}, '{32'h0003_FFFC, 1'b1},
            '{32'h0000_0000, 1'b1}, '{32'h0003_FFF0, 1'b0}};
    for (int i = 0; i < 1024; i++) begin ttag[i] = '0; tval[i] = 1'b1; end
    for (int i = 0; i < 16384; i++) dram[i] = '0;
    #3 reset_n = 1'b0;
    #1 chk("reset outputs", {31'b0, |{req_ready, tag_en, tag_we, data_en, mem_req_valid, resp_valid, flush_done}}, 0);
    sweep_check("por");
    for (int i = 0; i < 1024; i++)
      if (tval[i] !== 1'b0) begin chk("por tag invalid", {22'b0, 10'(i)}, 32'h3FF + 1); break; end
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].addr, tbl[i].miss, $sformatf("tbl%0d", i));
      if (i == 0) chk_line(tbl[i].addr, "cold");
    end
    chk_line(32'h0000_1048, "refetch");
    chk_line(32'h0003_FFFC, "lastline");
    rdy_delay = 10; gap_en = 1'b1;
    run(32'h0000_5550, 1'b1, "stall");
    chk_line(32'h0000_5550, "stall");
    rdy_delay = 0; gap_en = 1'b0;
    fork
      run(32'h0000_3064, 1'b1, "flush-refill");
      begin : w5
        int n;
        n = 0;
        while (!(data_we && data_idx[3:0] == 4'd5) && n < 500) begin @(negedge clock); n++; end
        chk("beat5 seen", {31'b0, n < 500}, 1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
      end
    join
    wait_flush_done("flush-refill");
    run(32'h0000_1048, 1'b1, "after flush");
    begin : rst_mid
      int n;
      n = 0;
      req_valid = 1'b1; req_addr = 32'h0000_2048;
      @(negedge clock);
      req_valid = 1'b0;
      while (!(data_we && data_idx[3:0] == 4'd7) && n < 500) begin @(negedge clock); n++; end
      chk("beat7 seen", {31'b0, n < 500}, 1);
      reset_n = 1'b0;
      #1 chk("mid reset outputs", {31'b0, |{req_ready, tag_en, tag_we, data_en, data_we, mem_req_valid, resp_valid}}, 0);
      chk("mid reset resp_data", resp_data, 0);
      sweep_check("mid reset");
    end
    run(32'h0000_2048, 1'b1, "abandoned line");
    for (int it = 0; it < 120; it++) begin
      a = {14'b0, 2'($urandom_range(0, 3)), 7'b0, 3'($urandom_range(0, 7)), 4'($urandom), 2'($urandom)};
      rdy_delay = $urandom_range(0, 3);
      gap_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        wait_flush_done("rand flush");
      end
      run(a, !(valid_m[a[15:6]] && tag_m[a[15:6]] == a[31:16]), $sformatf("rand%0d", it));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
